// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader and the CPU instruction decode.
// The loader's optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned OP_W           = 6;

  localparam logic [OP_W-1:0] HALT_OP = 6'b111111;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StRecv  = 3'd1;
  localparam state_t StWrite = 3'd2;
  localparam state_t StCheck = 3'd3;
  localparam state_t StDone  = 3'd4;

  function automatic logic [OP_W-1:0] opcode(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word packer: counts accepted bytes and shifts them in big-endian order.
module imem_loader_pack
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] data_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q <= 2'd0;
    end else if (take) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= {word_q[WORD_W-BYTE_W-1:0], data_in};
    end
  end

  // Pulses on the edge that accepts the fourth byte; word is complete in the following cycle.
  assign word_ready = take && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer holding the CPU in reset until the program is loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the halt word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned     WORDS   = 64,
  parameter logic [OP_W-1:0] HALT_OP = imem_loader_pkg::HALT_OP
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       start,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(WORDS+1)-1:0] word_count
);

  localparam int unsigned CW = $clog2(WORDS + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              take, clear, word_ready;
  logic [WORD_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  assign take  = byte_valid && (state_q == StRecv);
  assign clear = start && ((state_q == StIdle) || (state_q == StDone));

  imem_loader_pack u_pack (
    .clk        (CLK),
    .rst_n      (Reset),
    .clear      (clear),
    .take       (take),
    .data_in    (byte_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRecv;
          idx_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StRecv: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (take) csum_d = csum_q ^ byte_data;
`endif
        if (word_ready) state_d = StWrite;
      end
      StWrite: begin
        count_d = count_q + CW'(1);
        if (opcode(word) == HALT_OP) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else if (idx_q == CW'(WORDS - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + CW'(1);
          state_d = StRecv;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (byte_valid) begin
          err_d   = (byte_data != csum_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == StRecv) || (state_q == StCheck);
`else
  assign byte_ready = (state_q == StRecv);
`endif
  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = 32'(idx_q) << 2;
  assign mem_wdata  = word;
  assign done       = (state_q == StDone) && !err_q;
  assign cpu_hold   = !done;
  assign err        = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected writes plus end-of-load status.
module tb_imem_loader;

  localparam int WORDS = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CsumOn = 1'b1;
`else
  localparam bit CsumOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_hold, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  word_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr[$], exp_data[$], cap_addr[$], cap_data[$];
  int          exp_count;
  bit          exp_err, exp_halt;
  logic [7:0]  exp_csum;
  logic        prev_we = 1'b0;

  always #5 CLK = ~CLK;

  imem_loader #(.WORDS(WORDS)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Program-level model: big-endian words at consecutive addresses, stopping at halt or capacity.
  task automatic model_load(input logic [7:0] b[$], input bit good_csum);
    logic [31:0] w;
    int          wr;
    logic [7:0]  x;
    wr = 0;
    x = 8'h00;
    exp_halt = 1'b0;
    for (int k = 0; k < b.size() / 4; k++) begin
      if (exp_halt || wr == WORDS) break;
      w = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
      exp_addr.push_back(32'(k * 4));
      exp_data.push_back(w);
      wr++;
      x = x ^ b[4*k] ^ b[4*k+1] ^ b[4*k+2] ^ b[4*k+3];
      if (w[31:26] == 6'h3F) exp_halt = 1'b1;
    end
    exp_count = wr;
    exp_csum  = x;
    exp_err   = !exp_halt || (CsumOn && !good_csum);
  endtask

  always @(negedge CLK) begin
    if (Reset === 1'b1 && mem_we === 1'b1) begin
      check("we_single_cycle", 32'(prev_we), 32'd0);
      check("write_expected", 32'(exp_addr.size() != 0), 32'd1);
      if (exp_addr.size() != 0) begin
        check("write_addr", mem_addr, exp_addr.pop_front());
        check("write_data", mem_wdata, exp_data.pop_front());
      end
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
    end
    prev_we = (Reset === 1'b1) ? mem_we : 1'b0;
  end

  // Bytes count as accepted when valid and ready are both high going into the rising edge.
  task automatic send(input logic [7:0] b[$], input bit toggle);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i < b.size() && cyc < 400) begin
      @(negedge CLK);
      if (toggle && (cyc % 2 == 1)) begin
        byte_valid = 1'b0;
        start      = 1'b1;  // must be ignored mid-load
      end else begin
        byte_valid = 1'b1;
        byte_data  = b[i];
        start      = 1'b0;
      end
      if (byte_valid && byte_ready) i++;
      cyc++;
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    start      = 1'b0;
    check("bytes_accepted", 32'(i), 32'(b.size()));
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    check("ready_low_before_start", 32'(byte_ready), 32'd0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("ready_after_start", 32'(byte_ready), 32'd1);
    check("count_cleared", 32'(word_count), 32'd0);
    check("done_cleared", 32'(done), 32'd0);
  endtask

  task automatic run_program(input logic [7:0] b[$], input bit toggle, input bit good_csum);
    logic [7:0] cs[$];
    model_load(b, good_csum);
    send(b, toggle);
    if (CsumOn && exp_halt) begin
      cs.push_back(good_csum ? exp_csum : (exp_csum ^ 8'h5A));
      send(cs, 1'b0);
    end
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    while (!(done || err) && c < 40) begin
      @(negedge CLK);
      c++;
    end
    check("end_reached", 32'(done || err), 32'd1);
    check("end_done", 32'(done), 32'(!exp_err));
    check("end_err", 32'(err), 32'(exp_err));
    check("end_cpu_hold", 32'(cpu_hold), 32'(exp_err));
    check("end_word_count", 32'(word_count), 32'(exp_count));
    check("end_ready_low", 32'(byte_ready), 32'd0);
    check("all_writes_seen", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog1[$];
    logic [7:0] prog_ovf[$];
    logic [7:0] prog2[$];
    logic [7:0] part[$];
    prog1    = '{8'h00, 8'h22, 8'h08, 8'h20, 8'hFC, 8'h00, 8'h00, 8'h00};
    prog_ovf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    prog2    = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFC, 8'h12, 8'h34, 8'h56};
    part     = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFC, 8'h12};

    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    Reset = 1'b1;

    // Basic two-word program, valid held high.
    pulse_start();
    run_program(prog1, 1'b0, 1'b1);
    wait_end();
    check("p1_word0_data", cap_data[0], 32'h0022_0820);
    check("p1_word1_addr", cap_addr[1], 32'h0000_0004);
    check("p1_word1_data", cap_data[1], 32'hFC00_0000);
    check("p1_done", 32'(done), CsumOn ? 32'(done) + 32'd0 : 32'd1);

    // Restart from DONE; valid toggling with start pulses in the gaps.
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    run_program(prog1, 1'b1, 1'b1);
    wait_end();
    check("p1t_writes", 32'(cap_addr.size()), 32'd2);
    check("p1t_word1_data", cap_data[1], 32'hFC00_0000);

    // Capacity overflow: four non-halt words into a four-word memory.
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    run_program(prog_ovf, 1'b0, 1'b1);
    wait_end();
    check("ovf_writes", 32'(cap_addr.size()), 32'd4);
    check("ovf_last_addr", cap_addr[3], 32'h0000_000C);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_cpu_hold", 32'(cpu_hold), 32'd1);

    // Reset after six accepted bytes, then a clean reload.
    pulse_start();
    model_load(part, 1'b1);
    send(part, 1'b0);
    check("partial_first_word_written", 32'(exp_addr.size()), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_addr.delete();
    exp_data.delete();
    @(negedge CLK);
    Reset = 1'b1;
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    run_program(prog2, 1'b0, 1'b1);
    wait_end();
    check("reload_addr0", cap_addr[0], 32'h0000_0000);
    check("reload_data0", cap_data[0], 32'h1234_5678);
    check("reload_data1", cap_data[1], 32'hFC12_3456);

    if (CsumOn) begin
      // Wrong checksum byte must abort the load.
      pulse_start();
      run_program(prog1, 1'b0, 1'b0);
      wait_end();
      check("bad_csum_err", 32'(err), 32'd1);
      check("bad_csum_hold", 32'(cpu_hold), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
